data_sync_bus_capture: RTL and testbench
========================================

# data_sync_bus_capture

Receive-side capture stage for the multi-bit data synchronizer. It consumes the already-synchronized enable level produced by the enable synchronizer in the destination clock domain. On each rising edge of that level it samples the quasi-static source bus into a small FIFO. Captured words are presented to the destination logic through a valid/ready handshake, and a one-cycle enable pulse is emitted per capture.

## Interface
- BUS_WIDTH, default 8: width of the transferred data bus.
- DEPTH, default 2: capture FIFO depth in words; power of two, minimum 2.
- CLK  input  1  destination-domain clock; all logic on rising edge.
- RST  input  1  asynchronous, active-low reset.
- SYNC_EN  input  1  synchronized enable level from the enable synchronizer stage.
- UNSYNC_BUS  input  BUS_WIDTH  source-domain data; guaranteed stable while SYNC_EN is high and for the synchronizer latency before it.
- SYNC_READY  input  1  downstream accepts the head word this cycle.
- SYNC_BUS  output  BUS_WIDTH  head-of-FIFO word; reset 0.
- SYNC_VALID  output  1  FIFO non-empty; reset 0.
- ENABLE_PULSE  output  1  one-cycle strobe per accepted capture; reset 0.
- BUS_OVF  output  1  sticky overrun flag; reset 0.

## Operation
- Edge detector:
  - en_q is a register holding SYNC_EN from the previous cycle; reset 0.
  - rise = SYNC_EN & ~en_q.
  - A level held high for many cycles yields exactly one rise.
- Push:
  - push = rise.
  - On push, UNSYNC_BUS is written at the write pointer.
  - The word is taken directly from UNSYNC_BUS in the rise cycle, with no extra flop stage.
- Pop: pop = SYNC_VALID & SYNC_READY. The read pointer advances.
- FIFO:
  - Register-array storage.
  - Read/write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - A separate occupancy counter of log2(DEPTH)+1 bits runs from 0..DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Push accepted if ~full, or if full and pop occurs in the same cycle.
- Simultaneous accepted push + pop: count unchanged, both pointers advance.
- Push while empty: the word appears on SYNC_BUS the next cycle. There is no combinational bypass from UNSYNC_BUS to SYNC_BUS.
- Rejected push (full, no pop):
  - The word is discarded.
  - FIFO contents and pointers are unchanged.
  - No ENABLE_PULSE.
  - Overrun handling is described under Configuration.
- SYNC_BUS:
  - SYNC_BUS = storage[rd_ptr] when SYNC_VALID.
  - SYNC_BUS is held at the last popped value when empty; 0 after reset.
- SYNC_READY while SYNC_VALID=0 has no effect.
- Reset mid-operation:
  - All pointers, count, en_q, ENABLE_PULSE and BUS_OVF clear immediately.
  - Storage contents need not clear, but SYNC_BUS must read 0 until the first push.
  - If SYNC_EN is high when RST releases, en_q=0 means a rise is seen on the first clock and one capture occurs.

## Timing
- Capture latency: rise sampled at edge N → SYNC_VALID=1 and SYNC_BUS valid after edge N.
- ENABLE_PULSE is registered: high for exactly the one cycle following edge N.
- Pop at edge M: the next word is visible after edge M. SYNC_VALID drops after edge M if it was the last word.
- Throughput: one push and one pop per cycle. Minimum SYNC_EN spacing is 1 high + 1 low cycle per capture.
- All outputs are registered or derived from registered state only. No input-to-output combinational paths.

## Configuration
- Macro: DATA_SYNC_CAPTURE_OVF_DETECT_EN.
- Defined:
  - A rejected push sets BUS_OVF on the next edge.
  - BUS_OVF stays set until RST.
  - Pops do not clear it.
- Undefined:
  - BUS_OVF is tied to 0 and no overrun logic is synthesized.
  - Rejected pushes are still silently dropped.

## Test plan
- Reset: RST=0 with SYNC_EN=1, then release → all outputs 0 during reset. One capture on the first edge after release; SYNC_VALID=1 next cycle.
- Single transfer:
  - Stimulus: UNSYNC_BUS=0xA5, SYNC_EN held high for 5 cycles, SYNC_READY=1.
  - Response: exactly one ENABLE_PULSE and SYNC_BUS=0xA5 with SYNC_VALID=1 for one cycle, then SYNC_VALID=0.
- Back-pressure fill (DEPTH=2):
  - Stimulus: SYNC_READY=0, three rises carrying 0x11, 0x22, 0x33.
  - Response: two ENABLE_PULSEs; 0x33 dropped; BUS_OVF=1 with macro, 0 without.
  - Then SYNC_READY=1 → pops 0x11, 0x22 in order; BUS_OVF stays 1.
- Full + simultaneous pop/push:
  - Stimulus: FIFO holds 0x11, 0x22; SYNC_READY=1 in the same cycle as a rise carrying 0x44.
  - Response: 0x44 accepted, ENABLE_PULSE=1, no overrun; output sequence 0x11, 0x22, 0x44.
- Wrap-around:
  - Stimulus: 10 rises (values 0..9) with SYNC_READY toggling every cycle.
  - Response: all 10 values out in order, no loss, pointers wrap correctly.
- Mid-stream reset: assert RST with two words queued → SYNC_VALID, SYNC_BUS and BUS_OVF are 0 immediately (asynchronously); no stale word appears after release.

Source files
------------

// File: rtl/data_sync_bus_capture.sv
// Destination-domain capture stage: samples the source bus on each rising edge of the
// synchronized enable into a small FIFO. Optional overrun flag: DATA_SYNC_CAPTURE_OVF_DETECT_EN.
module data_sync_bus_capture #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SYNC_EN,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 SYNC_READY,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 SYNC_VALID,
  output logic                 ENABLE_PULSE,
  output logic                 BUS_OVF
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [BUS_WIDTH-1:0] last_q;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 en_q;
  logic                 pulse_q;

  logic rise;
  logic pop;
  logic full;
  logic push_ok;

  assign rise    = SYNC_EN & ~en_q;
  assign full    = (count == FULL_CNT);
  assign pop     = SYNC_VALID & SYNC_READY;
  // A full FIFO can still take the new word when the head leaves in the same cycle.
  assign push_ok = rise & (~full | pop);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_q    <= 1'b0;
      pulse_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last_q  <= '0;
    end else begin
      en_q    <= SYNC_EN;
      pulse_q <= push_ok;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        last_q <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; an empty FIFO never exposes it.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= UNSYNC_BUS;
  end

  assign SYNC_VALID   = (count != '0);
  assign SYNC_BUS     = SYNC_VALID ? mem[rd_ptr] : last_q;
  assign ENABLE_PULSE = pulse_q;

`ifdef DATA_SYNC_CAPTURE_OVF_DETECT_EN
  logic ovf_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_q <= 1'b0;
    end else if (rise && !push_ok) begin
      ovf_q <= 1'b1;
    end
  end

  assign BUS_OVF = ovf_q;
`else
  assign BUS_OVF = 1'b0;
`endif

endmodule

// File: tb/tb_data_sync_bus_capture.sv
// Directed bench for data_sync_bus_capture (DEPTH=2, BUS_WIDTH=8).
// Expected BUS_OVF follows DATA_SYNC_CAPTURE_OVF_DETECT_EN.
module tb_data_sync_bus_capture;

`ifdef DATA_SYNC_CAPTURE_OVF_DETECT_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       SYNC_EN;
  logic [7:0] UNSYNC_BUS;
  logic       SYNC_READY;
  logic [7:0] SYNC_BUS;
  logic       SYNC_VALID;
  logic       ENABLE_PULSE;
  logic       BUS_OVF;

  int checks   = 0;
  int failures = 0;

  data_sync_bus_capture #(.BUS_WIDTH(8), .DEPTH(2)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SYNC_EN      (SYNC_EN),
    .UNSYNC_BUS   (UNSYNC_BUS),
    .SYNC_READY   (SYNC_READY),
    .SYNC_BUS     (SYNC_BUS),
    .SYNC_VALID   (SYNC_VALID),
    .ENABLE_PULSE (ENABLE_PULSE),
    .BUS_OVF      (BUS_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic capture(input logic [7:0] val);
    UNSYNC_BUS = val;
    SYNC_EN    = 1'b1;
    tick();
    SYNC_EN    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b0; SYNC_EN = 1'b1; UNSYNC_BUS = 8'h5A; SYNC_READY = 1'b0;
    tick(); tick();
    checks++;
    if ({SYNC_VALID, ENABLE_PULSE, BUS_OVF} !== 3'b000 || SYNC_BUS !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b pulse=%b ovf=%b bus=%h, required 0 0 0 00",
               SYNC_VALID, ENABLE_PULSE, BUS_OVF, SYNC_BUS);
    end
    RST = 1'b1;
    tick();
    checks++;
    if (SYNC_VALID !== 1'b1 || SYNC_BUS !== 8'h5A || ENABLE_PULSE !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_capture: valid=%b bus=%h pulse=%b, required 1 5a 1",
               SYNC_VALID, SYNC_BUS, ENABLE_PULSE);
    end
    tick();
    checks++;
    if (ENABLE_PULSE !== 1'b0 || SYNC_VALID !== 1'b1) begin
      failures++;
      $display("FAIL reset_level_held: pulse=%b valid=%b, required 0 1", ENABLE_PULSE, SYNC_VALID);
    end
    SYNC_EN = 1'b0; SYNC_READY = 1'b1;
    tick();
    checks++;
    if (SYNC_VALID !== 1'b0 || SYNC_BUS !== 8'h5A) begin
      failures++;
      $display("FAIL reset_drain_hold: valid=%b bus=%h, required 0 5a", SYNC_VALID, SYNC_BUS);
    end
    SYNC_READY = 1'b0;
  endtask

  task automatic test_single();
    int pulses = 0;
    int valids = 0;
    logic [7:0] seen = 8'h00;
    UNSYNC_BUS = 8'hA5; SYNC_EN = 1'b1; SYNC_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ENABLE_PULSE === 1'b1) pulses++;
      if (SYNC_VALID === 1'b1) begin
        valids++;
        seen = SYNC_BUS;
      end
      if (i == 4) SYNC_EN = 1'b0;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL single_pulses: got %0d, required 1", pulses);
    end
    checks++;
    if (valids != 1 || seen !== 8'hA5) begin
      failures++;
      $display("FAIL single_data: valid_cycles=%0d bus=%h, required 1 a5", valids, seen);
    end
    SYNC_READY = 1'b0;
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    SYNC_READY = 1'b0;
    UNSYNC_BUS = 8'h11; SYNC_EN = 1'b1; tick(); if (ENABLE_PULSE === 1'b1) pulses++;
    SYNC_EN = 1'b0; tick();
    UNSYNC_BUS = 8'h22; SYNC_EN = 1'b1; tick(); if (ENABLE_PULSE === 1'b1) pulses++;
    SYNC_EN = 1'b0; tick();
    UNSYNC_BUS = 8'h33; SYNC_EN = 1'b1; tick(); if (ENABLE_PULSE === 1'b1) pulses++;
    SYNC_EN = 1'b0; tick();
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL bp_pulses: got %0d, required 2", pulses);
    end
    checks++;
    if (BUS_OVF !== OVF_EXP) begin
      failures++;
      $display("FAIL bp_ovf_set: got %b, required %b", BUS_OVF, OVF_EXP);
    end
    checks++;
    if (SYNC_VALID !== 1'b1 || SYNC_BUS !== 8'h11) begin
      failures++;
      $display("FAIL bp_head0: valid=%b bus=%h, required 1 11", SYNC_VALID, SYNC_BUS);
    end
    SYNC_READY = 1'b1;
    tick();
    checks++;
    if (SYNC_VALID !== 1'b1 || SYNC_BUS !== 8'h22) begin
      failures++;
      $display("FAIL bp_head1: valid=%b bus=%h, required 1 22", SYNC_VALID, SYNC_BUS);
    end
    tick();
    checks++;
    if (SYNC_VALID !== 1'b0 || SYNC_BUS !== 8'h22 || BUS_OVF !== OVF_EXP) begin
      failures++;
      $display("FAIL bp_drained: valid=%b bus=%h ovf=%b, required 0 22 %b",
               SYNC_VALID, SYNC_BUS, BUS_OVF, OVF_EXP);
    end
    SYNC_READY = 1'b0;
  endtask

  task automatic test_midstream_reset();
    SYNC_READY = 1'b0;
    capture(8'h66);
    capture(8'h77);
    RST = 1'b0;
    #2;
    checks++;
    if (SYNC_VALID !== 1'b0 || SYNC_BUS !== 8'h00 || BUS_OVF !== 1'b0 || ENABLE_PULSE !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: valid=%b bus=%h ovf=%b pulse=%b, required 0 00 0 0",
               SYNC_VALID, SYNC_BUS, BUS_OVF, ENABLE_PULSE);
    end
    tick(); tick();
    RST = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (SYNC_VALID !== 1'b0 || SYNC_BUS !== 8'h00) begin
      failures++;
      $display("FAIL midreset_no_stale: valid=%b bus=%h, required 0 00", SYNC_VALID, SYNC_BUS);
    end
  endtask

  task automatic test_full_pushpop();
    SYNC_READY = 1'b0;
    capture(8'h11);
    capture(8'h22);
    checks++;
    if (SYNC_BUS !== 8'h11 || SYNC_VALID !== 1'b1) begin
      failures++;
      $display("FAIL fpp_head0: valid=%b bus=%h, required 1 11", SYNC_VALID, SYNC_BUS);
    end
    UNSYNC_BUS = 8'h44; SYNC_EN = 1'b1; SYNC_READY = 1'b1;
    tick();
    SYNC_EN = 1'b0;
    checks++;
    if (ENABLE_PULSE !== 1'b1 || BUS_OVF !== 1'b0 || SYNC_BUS !== 8'h22) begin
      failures++;
      $display("FAIL fpp_accept: pulse=%b ovf=%b bus=%h, required 1 0 22",
               ENABLE_PULSE, BUS_OVF, SYNC_BUS);
    end
    tick();
    checks++;
    if (SYNC_VALID !== 1'b1 || SYNC_BUS !== 8'h44) begin
      failures++;
      $display("FAIL fpp_head2: valid=%b bus=%h, required 1 44", SYNC_VALID, SYNC_BUS);
    end
    tick();
    checks++;
    if (SYNC_VALID !== 1'b0 || BUS_OVF !== 1'b0) begin
      failures++;
      $display("FAIL fpp_drained: valid=%b ovf=%b, required 0 0", SYNC_VALID, BUS_OVF);
    end
    SYNC_READY = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] rx [$];
    int pulses = 0;
    for (int cyc = 0; cyc < 26; cyc++) begin
      SYNC_EN    = (cyc < 20) && (cyc % 2 == 0);
      UNSYNC_BUS = 8'(cyc / 2);
      SYNC_READY = (cyc % 2 == 1);
      if (SYNC_VALID === 1'b1 && SYNC_READY === 1'b1) rx.push_back(SYNC_BUS);
      tick();
      if (ENABLE_PULSE === 1'b1) pulses++;
    end
    SYNC_EN = 1'b0; SYNC_READY = 1'b0;
    checks++;
    if (rx.size() != 10 || pulses != 10) begin
      failures++;
      $display("FAIL wrap_count: received=%0d pulses=%0d, required 10 10", rx.size(), pulses);
    end
    for (int i = 0; i < rx.size() && i < 10; i++) begin
      checks++;
      if (rx[i] !== 8'(i)) begin
        failures++;
        $display("FAIL wrap_order[%0d]: got %h, required %h", i, rx[i], 8'(i));
      end
    end
    checks++;
    if (BUS_OVF !== 1'b0 || SYNC_VALID !== 1'b0) begin
      failures++;
      $display("FAIL wrap_end: ovf=%b valid=%b, required 0 0", BUS_OVF, SYNC_VALID);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_midstream_reset();
    test_full_pushpop();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
